// File: rtl/dec_pkg.sv
// -----------------------------------------------------------------------------
// dec_pkg -- shared types and helpers for the dec_scan decoder family.
//   state_t    : FSM state encoding (IDLE / DIRECT / SCAN)
//   onehot()   : index -> one-hot vector, MAX_OUT_W wide; callers size-cast
//                the result down to their own output width
//   cnt_width(): dwell counter width, $clog2(dwell) with a floor of 1
// Select widths up to MAX_SEL bits are supported by onehot().
// -----------------------------------------------------------------------------
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam int MAX_SEL   = 8;
  localparam int MAX_OUT_W = 1 << MAX_SEL;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL-1:0] n);
    return MAX_OUT_W'(1) << n;
  endfunction

  function automatic int cnt_width(input int dwell);
    return (dwell <= 1) ? 1 : $clog2(dwell);
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// -----------------------------------------------------------------------------
// dwell_counter -- modulo-DWELL counter with synchronous clear.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clear : hold the count at zero (block not scanning)
//   tc    : terminal-count strobe, high while counting and count == DWELL-1
// The count runs 0..DWELL-1 whenever clear is low, so each index is held for
// exactly DWELL cycles starting from a cleared count.
// -----------------------------------------------------------------------------
module dwell_counter
  import dec_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tc
);

  localparam int             CW   = cnt_width(DWELL);
  localparam logic [CW-1:0]  LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = !clear && (cnt == LAST);

endmodule

// File: rtl/dec_scan.sv
// -----------------------------------------------------------------------------
// dec_scan -- registered N-to-2^N one-hot decoder with enable and auto-scan.
//   N_SEL  : select width; output width OUT_W = 2**N_SEL (N_SEL <= 8)
//   DWELL  : cycles each line is held in scan mode (1..65536)
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   in     : direct-mode select, or start index on scan entry
//   enable : low forces all outputs to zero and idles the block
//   mode   : 0 = direct decode, 1 = auto-scan
//   out    : registered one-hot output (all zero when disabled)
//   idx    : index currently decoded; holds its value while disabled
//   wrap   : one-cycle pulse on the cycle idx steps OUT_W-1 -> 0 in scan
// All outputs are registered; there is no input-to-output combinational path.
// -----------------------------------------------------------------------------
module dec_scan
  import dec_pkg::*;
#(
  parameter  int N_SEL = 2,
  parameter  int DWELL = 4,
  localparam int OUT_W = 1 << N_SEL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SEL-1:0] in,
  input  logic             enable,
  input  logic             mode,
  output logic [OUT_W-1:0] out,
  output logic [N_SEL-1:0] idx,
  output logic             wrap
);

  state_t           state;
  logic             scan_run;
  logic             tc;
  logic [N_SEL-1:0] idx_inc;
  logic [OUT_W-1:0] hot_in;
  logic [OUT_W-1:0] hot_inc;

  // The counter only runs while we stay in SCAN; any exit (disable or mode
  // change) and the entry cycle itself see it cleared, so a scan always
  // starts a fresh dwell on its entry index.
  assign scan_run = enable && mode && (state == SCAN);

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!scan_run),
    .tc    (tc)
  );

  // NOTE: every variable driven here gets a value on every pass, so no
  // latch can be inferred.
  always_comb begin
    idx_inc = idx + N_SEL'(1);
    hot_in  = OUT_W'(onehot(MAX_SEL'(in)));
    hot_inc = OUT_W'(onehot(MAX_SEL'(idx_inc)));
  end

  // Single-process FSM; out and idx are loaded together so out is one-hot of
  // idx on every cycle while enabled, never multi-hot across transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out   <= '0;
      idx   <= '0;
      wrap  <= 1'b0;
    end else if (!enable) begin
      state <= IDLE;          // idx deliberately holds its last value
      out   <= '0;
      wrap  <= 1'b0;
    end else if (!mode) begin
      state <= DIRECT;
      idx   <= in;
      out   <= hot_in;
      wrap  <= 1'b0;
    end else if (state != SCAN) begin
      state <= SCAN;          // scan entry from IDLE or DIRECT
      idx   <= in;
      out   <= hot_in;
      wrap  <= 1'b0;
    end else if (tc) begin
      idx   <= idx_inc;
      out   <= hot_inc;
      wrap  <= &idx;          // stepping from OUT_W-1 back to 0
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dec_scan.sv
// -----------------------------------------------------------------------------
// tb_dec_scan -- scoreboard bench for dec_scan.
// dut_a: N_SEL=2, DWELL=3.  dut_b: N_SEL=3, DWELL=1.
// Stimulus is driven on the falling edge and the expected register contents
// after the next rising edge are queued; the monitor pops one entry per
// rising edge (sampled 1 ns later) and compares.  Asynchronous reset effects
// are checked directly at the instant they must appear.
// -----------------------------------------------------------------------------
module tb_dec_scan;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [1:0] a_in;
  logic       a_en, a_mode;
  logic [3:0] a_out;
  logic [1:0] a_idx;
  logic       a_wrap;

  logic [2:0] b_in;
  logic       b_en, b_mode;
  logic [7:0] b_out;
  logic [2:0] b_idx;
  logic       b_wrap;

  always #5 clk = ~clk;

  dec_scan #(.N_SEL(2), .DWELL(3)) dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (a_in),
    .enable (a_en),
    .mode   (a_mode),
    .out    (a_out),
    .idx    (a_idx),
    .wrap   (a_wrap)
  );

  dec_scan #(.N_SEL(3), .DWELL(1)) dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (b_in),
    .enable (b_en),
    .mode   (b_mode),
    .out    (b_out),
    .idx    (b_idx),
    .wrap   (b_wrap)
  );

  typedef struct {
    bit         sel_b;
    logic [7:0] out;
    logic [2:0] idx;
    logic       wrap;
    int         id;
  } exp_t;

  exp_t sb[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   step_id = 0;

  // Expected scan index sequence for dut_a entering at 1 with DWELL=3.
  logic [1:0] scan_seq [15] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3,
                                2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};

  task automatic check(input string name, input int id,
                       input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got %0h, expected %0h (t=%0t)", name, id, act, exp, $time);
    end
  endtask

  task automatic step_a(input logic [1:0] i, input logic en, input logic m,
                        input logic [3:0] eo, input logic [1:0] ei, input logic ew);
    exp_t e;
    @(negedge clk);
    a_in = i; a_en = en; a_mode = m;
    e.sel_b = 1'b0; e.out = {4'b0, eo}; e.idx = {1'b0, ei}; e.wrap = ew; e.id = step_id;
    step_id++;
    sb.push_back(e);
  endtask

  task automatic step_b(input logic [2:0] i, input logic en, input logic m,
                        input logic [7:0] eo, input logic [2:0] ei, input logic ew);
    exp_t e;
    @(negedge clk);
    b_in = i; b_en = en; b_mode = m;
    e.sel_b = 1'b1; e.out = eo; e.idx = ei; e.wrap = ew; e.id = step_id;
    step_id++;
    sb.push_back(e);
  endtask

  // Monitor: one expected entry per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (!e.sel_b) begin
          check("a_out",  e.id, {4'b0, a_out},  e.out);
          check("a_idx",  e.id, {6'b0, a_idx},  {5'b0, e.idx[1:0]});
          check("a_wrap", e.id, {7'b0, a_wrap}, {7'b0, e.wrap});
        end else begin
          check("b_out",  e.id, b_out,          e.out);
          check("b_idx",  e.id, {5'b0, b_idx},  {5'b0, e.idx});
          check("b_wrap", e.id, {7'b0, b_wrap}, {7'b0, e.wrap});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got unfinished run, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_in = 2'd2; a_en = 1'b1; a_mode = 1'b0;
    b_in = 3'd0; b_en = 1'b0; b_mode = 1'b0;

    // Reset state, with enable/mode already asserted.
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_out",  0, {4'b0, a_out},  8'h00);
    check("rst_a_idx",  0, {6'b0, a_idx},  8'h00);
    check("rst_a_wrap", 0, {7'b0, a_wrap}, 8'h00);
    check("rst_b_out",  0, b_out,          8'h00);
    rst_n = 1'b1;

    // First decode after release.
    step_a(2'd2, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0);

    // Direct sweep, then disable: out clears, idx holds.
    step_a(2'd0, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0);
    step_a(2'd1, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0);
    step_a(2'd2, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0);
    step_a(2'd3, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b0);
    step_a(2'd3, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0);
    step_a(2'd0, 1'b0, 1'b1, 4'b0000, 2'd3, 1'b0);

    // Scan from 1 for 15 cycles; in changes after entry and must be ignored.
    for (int k = 0; k < 15; k++) begin
      step_a((k == 0) ? 2'd1 : 2'(k), 1'b1, 1'b1,
             4'b0001 << scan_seq[k], scan_seq[k], k == 9);
    end
    step_a(2'd0, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b0);

    // Mode toggle mid-dwell, then re-entry holds for a full dwell.
    step_a(2'd0, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
    step_a(2'd3, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
    step_a(2'd3, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b0);
    step_a(2'd2, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0);
    step_a(2'd0, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0);
    step_a(2'd0, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0);
    step_a(2'd0, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0);
    step_a(2'd0, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0);

    // Asynchronous reset mid-cycle while scanning at idx=3.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_a_out",  0, {4'b0, a_out},  8'h00);
    check("arst_a_idx",  0, {6'b0, a_idx},  8'h00);
    check("arst_a_wrap", 0, {7'b0, a_wrap}, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("arst_a_wrap_hold", k, {7'b0, a_wrap}, 8'h00);
    end
    a_en  = 1'b0;
    rst_n = 1'b1;
    step_a(2'd1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);

    // dut_b: direct decode, then DWELL=1 scan stepping every cycle.
    step_b(3'd5, 1'b1, 1'b0, 8'h20, 3'd5, 1'b0);
    step_b(3'd7, 1'b1, 1'b0, 8'h80, 3'd7, 1'b0);
    step_b(3'd0, 1'b1, 1'b1, 8'h01, 3'd0, 1'b0);
    for (int k = 1; k < 20; k++) begin
      step_b(3'(k), 1'b1, 1'b1, 8'h01 << (k % 8), 3'(k % 8), (k % 8) == 0);
    end

    // Asynchronous reset mid-cycle during the DWELL=1 scan at idx=3.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_b_out",  0, b_out,          8'h00);
    check("arst_b_idx",  0, {5'b0, b_idx},  8'h00);
    check("arst_b_wrap", 0, {7'b0, b_wrap}, 8'h00);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("arst_b_wrap_hold", k, {7'b0, b_wrap}, 8'h00);
    end
    b_en  = 1'b0;
    rst_n = 1'b1;
    step_b(3'd4, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
    #2;
    check("sb_drain", 0, 8'(sb.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
